// File: rtl/mvau_weight_stream.sv
// Weight read sequencer and 2-deep stream buffer for one MVAU PE lane.
// Issues reads to a synchronous-read weight memory and delivers words in address order.
module mvau_weight_stream #(
  parameter int SIMD         = 2,
  parameter int TW           = 1,
  parameter int WMEM_DEPTH   = 4,
  parameter int WMEM_ADDR_BW = 4
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    en,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  input  logic [SIMD*TW-1:0]      wmem_out,
  output logic                    wstrm_v,
  input  logic                    wstrm_rdy,
  output logic [SIMD*TW-1:0]      wstrm_data,
  output logic                    wstrm_last,
  output logic [1:0]              dbg_occ,
  output logic                    dbg_inflight
);

  localparam int DW = SIMD * TW;
  localparam logic [WMEM_ADDR_BW-1:0] LAST_ADDR = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  logic [WMEM_ADDR_BW-1:0] addr;
  logic                    inflight;
  logic                    inflight_last;
  logic [1:0]              occ;
  logic [1:0]              occ_after_pop;
  logic [DW-1:0]           head_data;
  logic                    head_last;
  logic [DW-1:0]           tail_data;
  logic                    tail_last;
  logic                    pop;
  logic                    push;
  logic                    issue;
  logic                    at_last;
  logic [2:0]              credit_used;

  // Stream handshake: a word transfers on every edge where wstrm_v && wstrm_rdy;
  // once wstrm_v is high it and the head word hold until that transfer happens.
  always_comb begin
    pop           = wstrm_v && wstrm_rdy;
    push          = inflight;
    at_last       = (addr == LAST_ADDR);
    credit_used   = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};
    issue         = en && (credit_used < 3'd2);
    occ_after_pop = occ - {1'b0, pop};
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr          <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_last <= at_last;
        addr          <= at_last ? '0 : addr + WMEM_ADDR_BW'(1);
      end
    end
  end

  // The memory re-reads every edge, so the landing word is captured unconditionally;
  // the credit check above guarantees a free slot.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      occ       <= 2'd0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      if (pop) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end
      if (push) begin
        if (occ_after_pop == 2'd0) begin
          head_data <= wmem_out;
          head_last <= inflight_last;
        end else begin
          tail_data <= wmem_out;
          tail_last <= inflight_last;
        end
      end
      occ <= occ_after_pop + {1'b0, push};
    end
  end

  assign wmem_addr    = addr;
  assign wstrm_v      = (occ != 2'd0);
  assign wstrm_data   = head_data;
  assign wstrm_last   = head_last;
  assign dbg_occ      = occ;
  assign dbg_inflight = inflight;

endmodule

// File: tb/tb_mvau_weight_stream.sv
// Bench for mvau_weight_stream: three instances (depth 4, depth 5, depth 1) each with a
// synchronous-read memory model; expected words come from address-order arithmetic.
module tb_mvau_weight_stream;

  logic aclk    = 1'b0;
  logic aresetn = 1'b1;
  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: SIMD=2, TW=4, depth 4
  logic       en_a = 1'b0, rdy_a = 1'b0;
  logic [3:0] addr_a;
  logic [7:0] mout_a, data_a;
  logic       v_a, last_a, infl_a;
  logic [1:0] occ_a;
  logic [7:0] mem_a [4];

  // instance B: SIMD=2, TW=4, depth 5
  logic       en_b = 1'b0, rdy_b = 1'b0;
  logic [3:0] addr_b;
  logic [7:0] mout_b, data_b;
  logic       v_b, last_b, infl_b;
  logic [1:0] occ_b;
  logic [7:0] mem_b [5];

  // instance C: SIMD=1, TW=8, depth 1
  logic       en_c = 1'b0, rdy_c = 1'b0;
  logic [3:0] addr_c;
  logic [7:0] mout_c, data_c;
  logic       v_c, last_c, infl_c;
  logic [1:0] occ_c;
  logic [7:0] mem_c_word = 8'hA5;

  always @(posedge aclk) begin
    mout_a <= mem_a[addr_a[1:0]];
    mout_b <= mem_b[addr_b[2:0]];
    mout_c <= (addr_c == 4'd0) ? mem_c_word : 8'h00;
  end

  mvau_weight_stream #(.SIMD(2), .TW(4), .WMEM_DEPTH(4), .WMEM_ADDR_BW(4)) u_a (
    .aclk(aclk), .aresetn(aresetn), .en(en_a), .wmem_addr(addr_a), .wmem_out(mout_a),
    .wstrm_v(v_a), .wstrm_rdy(rdy_a), .wstrm_data(data_a), .wstrm_last(last_a),
    .dbg_occ(occ_a), .dbg_inflight(infl_a));

  mvau_weight_stream #(.SIMD(2), .TW(4), .WMEM_DEPTH(5), .WMEM_ADDR_BW(4)) u_b (
    .aclk(aclk), .aresetn(aresetn), .en(en_b), .wmem_addr(addr_b), .wmem_out(mout_b),
    .wstrm_v(v_b), .wstrm_rdy(rdy_b), .wstrm_data(data_b), .wstrm_last(last_b),
    .dbg_occ(occ_b), .dbg_inflight(infl_b));

  mvau_weight_stream #(.SIMD(1), .TW(8), .WMEM_DEPTH(1), .WMEM_ADDR_BW(4)) u_c (
    .aclk(aclk), .aresetn(aresetn), .en(en_c), .wmem_addr(addr_c), .wmem_out(mout_c),
    .wstrm_v(v_c), .wstrm_rdy(rdy_c), .wstrm_data(data_c), .wstrm_last(last_c),
    .dbg_occ(occ_c), .dbg_inflight(infl_c));

  // Release lands just after a rising edge; the next falling edge is cycle 0.
  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0;
    @(posedge aclk);
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_reset();
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    n_tests++;
    if ({addr_a, v_a, data_a, last_a, occ_a, infl_a} !== 17'd0) begin
      n_fail++; $display("FAIL reset_a: got %h required 0", {addr_a, v_a, data_a, last_a, occ_a, infl_a});
    end
    n_tests++;
    if ({addr_b, v_b, data_b, last_b, occ_b, infl_b} !== 17'd0) begin
      n_fail++; $display("FAIL reset_b: got %h required 0", {addr_b, v_b, data_b, last_b, occ_b, infl_b});
    end
    n_tests++;
    if ({addr_c, v_c, data_c, last_c, occ_c, infl_c} !== 17'd0) begin
      n_fail++; $display("FAIL reset_c: got %h required 0", {addr_c, v_c, data_c, last_c, occ_c, infl_c});
    end
    @(posedge aclk);
    #1 aresetn = 1'b1;
  endtask

  task automatic test_stream_wrap();
    int idx;
    en_a = 1'b1; rdy_a = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge aclk);
      n_tests++;
      if (v_a !== (cyc >= 2)) begin
        n_fail++; $display("FAIL wrap_valid cyc %0d: got %b required %b", cyc, v_a, (cyc >= 2));
      end
      if (cyc >= 2) begin
        idx = (cyc - 2) % 4;
        n_tests++;
        if (data_a !== mem_a[idx] || last_a !== (idx == 3)) begin
          n_fail++; $display("FAIL wrap_word cyc %0d: got %h/%b required %h/%b",
                             cyc, data_a, last_a, mem_a[idx], (idx == 3));
        end
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_backpressure();
    int k = 0;
    logic prev_hold = 1'b0;
    logic [7:0] held = 8'h00;
    en_a = 1'b1; rdy_a = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge aclk);
      rdy_a = !(cyc >= 8 && cyc < 14);
      if (v_a) begin
        n_tests++;
        if (data_a !== mem_a[k % 4] || last_a !== ((k % 4) == 3)) begin
          n_fail++; $display("FAIL bp_order cyc %0d: got %h/%b required %h/%b",
                             cyc, data_a, last_a, mem_a[k % 4], ((k % 4) == 3));
        end
      end
      if (prev_hold) begin
        n_tests++;
        if (!v_a || data_a !== held) begin
          n_fail++; $display("FAIL bp_stable cyc %0d: got %b/%h required 1/%h", cyc, v_a, data_a, held);
        end
      end
      if (cyc >= 9 && cyc <= 13) begin
        n_tests++;
        if (occ_a !== 2'd2 || addr_a !== 4'((k + 2) % 4)) begin
          n_fail++; $display("FAIL bp_freeze cyc %0d: got occ %0d addr %0d required occ 2 addr %0d",
                             cyc, occ_a, addr_a, (k + 2) % 4);
        end
      end
      prev_hold = v_a && !rdy_a;
      held = data_a;
      if (v_a && rdy_a) k++;
    end
    n_tests++;
    if (k != 22) begin
      n_fail++; $display("FAIL bp_count: got %0d words required 22", k);
    end
    en_a = 1'b0;
  endtask

  task automatic test_random();
    logic [8:0] exp_q[$];
    logic [8:0] exp_w;
    logic [8:0] held = 9'd0;
    logic prev_hold = 1'b0;
    logic prev_en = 1'b1;
    logic [3:0] prev_addr = 4'd0;
    int delivered = 0;
    for (int i = 0; i < 2200; i++) exp_q.push_back({(i % 5) == 4, mem_b[i % 5]});
    en_b = 1'b1; rdy_b = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 2008; cyc++) begin
      @(negedge aclk);
      if (!prev_en) begin
        n_tests++;
        if (addr_b !== prev_addr) begin
          n_fail++; $display("FAIL rnd_addr_hold cyc %0d: got %0d required %0d", cyc, addr_b, prev_addr);
        end
      end
      if (cyc < 2000) begin
        en_b  = ($urandom_range(0, 3) != 0);
        rdy_b = ($urandom_range(0, 2) != 0);
      end else begin
        en_b = 1'b0; rdy_b = 1'b1;
      end
      n_tests++;
      if (int'(occ_b) + int'(infl_b) > 2 || v_b !== (occ_b != 2'd0)) begin
        n_fail++; $display("FAIL rnd_credit cyc %0d: got occ %0d inflight %b valid %b", cyc, occ_b, infl_b, v_b);
      end
      n_tests++;
      if (infl_b && occ_b == 2'd2 && !(v_b && rdy_b)) begin
        n_fail++; $display("FAIL rnd_overflow cyc %0d: got push into full buffer required none", cyc);
      end
      if (prev_hold) begin
        n_tests++;
        if (!v_b || {last_b, data_b} !== held) begin
          n_fail++; $display("FAIL rnd_stable cyc %0d: got %b/%h required 1/%h", cyc, v_b, {last_b, data_b}, held);
        end
      end
      if (v_b && rdy_b) begin
        exp_w = exp_q.pop_front();
        n_tests++;
        if ({last_b, data_b} !== exp_w) begin
          n_fail++; $display("FAIL rnd_word %0d: got %h required %h", delivered, {last_b, data_b}, exp_w);
        end
        delivered++;
      end
      prev_hold = v_b && !rdy_b;
      held = {last_b, data_b};
      prev_en = en_b;
      prev_addr = addr_b;
    end
    n_tests++;
    if (v_b !== 1'b0 || addr_b !== 4'(delivered % 5) || delivered < 100) begin
      n_fail++; $display("FAIL rnd_drain: got valid %b addr %0d words %0d required 0/%0d/>=100",
                         v_b, addr_b, delivered, delivered % 5);
    end
  endtask

  task automatic test_en_pulse();
    int nv = 0;
    en_a = 1'b0; rdy_a = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge aclk);
      en_a = (cyc == 0);
      if (v_a) begin
        nv++;
        n_tests++;
        if (data_a !== mem_a[0] || last_a !== 1'b0) begin
          n_fail++; $display("FAIL pulse_word: got %h/%b required %h/0", data_a, last_a, mem_a[0]);
        end
      end
    end
    n_tests++;
    if (nv != 1 || addr_a !== 4'd1) begin
      n_fail++; $display("FAIL pulse_count: got %0d words addr %0d required 1 word addr 1", nv, addr_a);
    end
  endtask

  task automatic test_async_reset();
    int waited = 0;
    en_a = 1'b1; rdy_a = 1'b1;
    do_reset();
    repeat (5) @(negedge aclk);
    rdy_a = 1'b0;
    @(negedge aclk);
    while (occ_a !== 2'd2 && waited < 10) begin
      @(negedge aclk);
      waited++;
    end
    n_tests++;
    if (occ_a !== 2'd2) begin
      n_fail++; $display("FAIL areset_fill: got occ %0d required 2", occ_a);
    end
    aresetn = 1'b0;
    #1;
    n_tests++;
    if ({v_a, data_a, last_a, addr_a, occ_a, infl_a} !== 17'd0) begin
      n_fail++; $display("FAIL areset_clear: got %h required 0", {v_a, data_a, last_a, addr_a, occ_a, infl_a});
    end
    @(posedge aclk);
    #1 aresetn = 1'b1;
    rdy_a = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge aclk);
      if (cyc == 1 || cyc == 2) begin
        n_tests++;
        if (v_a !== (cyc == 2) || (cyc == 2 && data_a !== mem_a[0])) begin
          n_fail++; $display("FAIL areset_restart cyc %0d: got %b/%h required %b/%h",
                             cyc, v_a, data_a, (cyc == 2), mem_a[0]);
        end
      end
    end
    en_a = 1'b0;
  endtask

  task automatic test_depth1();
    en_c = 1'b1; rdy_c = 1'b1;
    do_reset();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge aclk);
      rdy_c = (cyc < 10) ? 1'b1 : 1'($urandom_range(0, 1));
      n_tests++;
      if (addr_c !== 4'd0) begin
        n_fail++; $display("FAIL d1_addr cyc %0d: got %0d required 0", cyc, addr_c);
      end
      if (cyc >= 2 && cyc < 10) begin
        n_tests++;
        if (v_c !== 1'b1) begin
          n_fail++; $display("FAIL d1_valid cyc %0d: got %b required 1", cyc, v_c);
        end
      end
      if (v_c) begin
        n_tests++;
        if (data_c !== 8'hA5 || last_c !== 1'b1) begin
          n_fail++; $display("FAIL d1_word cyc %0d: got %h/%b required a5/1", cyc, data_c, last_c);
        end
      end
    end
    en_c = 1'b0;
  endtask

  initial begin
    mem_a[0] = 8'h10; mem_a[1] = 8'h21; mem_a[2] = 8'h32; mem_a[3] = 8'h43;
    for (int i = 0; i < 5; i++) mem_b[i] = {4'(i + 1), 4'($urandom_range(0, 15))};
    test_reset();
    test_stream_wrap();
    test_backpressure();
    test_random();
    test_en_pulse();
    test_async_reset();
    test_depth1();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
